// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan display.
// Holds the active-low hex segment codes, the blank and digit-off
// patterns, the display FSM state encoding and the captured-result payload.
package seg_pkg;

    localparam int unsigned RES_W = 32;

    // Active-low segment patterns. Bits 0..6 are segments a..g, bit 7 is dp.
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEL_OFF   = 8'hFF;

    // Element k is the pattern for hex digit k, with dp dark.
    localparam logic [15:0][7:0] SEG_HEX = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef enum logic {
        ST_OFF  = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    // One ALU result as captured from the handshake.
    typedef struct packed {
        logic             ov;
        logic [RES_W-1:0] res;
    } result_t;

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex-to-seven-segment decoder (active-low outputs).
// Ports:
//   i_nibble  4-bit hex digit value
//   i_blank   force all segments dark (dp dark as well)
//   i_dp_on   light the decimal point on a non-blank digit
//   o_seg_c   active-low segment code, bit0..6 = a..g, bit7 = dp
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    input  logic       i_dp_on,
    output logic [7:0] o_seg_c
);

    always_comb begin
        o_seg_c = SEG_BLANK;
        if (!i_blank) begin
            o_seg_c = SEG_HEX[i_nibble];
            if (i_dp_on) begin
                o_seg_c[7] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed 8-digit hex display for the ALU result path.
// A result is taken over a valid/ready handshake into a shadow register and
// moved to the display register only at a frame boundary so a frame is never
// torn. Leading zeros can be blanked and an overflow result blinks the dp.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready result handshake
//   res, overflow     ALU result and overflow flag
//   disp_en           display enable (scan runs while high)
//   seg_sel           active-low one-hot digit select, bit k = digit k
//   seg_out           active-low segments, bit0..6 = a..g, bit7 = dp
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int unsigned DATA_LEN    = 32,
    parameter int unsigned SCAN_DIV    = 1000,
    parameter int unsigned BLINK_DIV   = 64,
    parameter int unsigned LZ_SUPPRESS = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_LEN-1:0] res,
    input  logic                overflow,
    input  logic                disp_en,
    output logic [7:0]          seg_sel,
    output logic [7:0]          seg_out
);

    localparam int unsigned NUM_DIGITS = DATA_LEN / 4;
    localparam int unsigned DIG_W      = $clog2(NUM_DIGITS);
    localparam int unsigned SCAN_W     = $clog2(SCAN_DIV);
    localparam int unsigned FRAME_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DIG_W-1:0]   DIG_LAST   = DIG_W'(NUM_DIGITS - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_DIV - 1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic                r_in_ready;
    logic [SCAN_W-1:0]   r_scan_cnt;
    logic [DIG_W-1:0]    r_digit_idx;
    logic [FRAME_W-1:0]  r_frame_cnt;
    logic                r_blink;
    result_t             r_shadow;
    result_t             r_disp;
    logic                r_pending;
    logic [7:0]          r_seg_sel;
    logic [7:0]          r_seg_out;

    result_t             w_in;
    logic                w_accept;
    logic                w_fb;
    logic [DIG_W+1:0]    w_shamt;
    logic [RES_W-1:0]    w_upper;
    logic                w_blank;
    logic                w_dp_on;
    logic [7:0]          w_dec_seg;
    logic [7:0]          w_sel_nxt;
    logic [7:0]          w_seg_nxt;

    assign in_ready = r_in_ready;
    assign seg_sel  = r_seg_sel;
    assign seg_out  = r_seg_out;

    assign w_in.ov  = overflow;
    assign w_in.res = RES_W'(res);
    assign w_accept = in_valid & r_in_ready;
    assign w_fb     = (w_state_nxt == ST_SCAN) && (r_scan_cnt == SCAN_LAST)
                      && (r_digit_idx == DIG_LAST);

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: scanning follows the enable.
    always_comb begin
        w_state_nxt = ST_OFF;
        if (disp_en) begin
            w_state_nxt = ST_SCAN;
        end
    end

    // Digit k is blank when it and every more significant nibble are zero.
    assign w_shamt = {r_digit_idx, 2'b00};
    assign w_upper = r_disp.res >> w_shamt;
    assign w_blank = (LZ_SUPPRESS != 0) && (r_digit_idx != '0) && (w_upper == '0);
    assign w_dp_on = r_disp.ov & r_blink;

    seg_hex_decoder u_dec (
        .i_nibble (w_upper[3:0]),
        .i_blank  (w_blank),
        .i_dp_on  (w_dp_on),
        .o_seg_c  (w_dec_seg)
    );

    // FSM outputs: next digit select / segment pattern, registered below.
    always_comb begin
        w_sel_nxt = SEL_OFF;
        w_seg_nxt = SEG_BLANK;
        if (w_state_nxt == ST_SCAN) begin
            w_sel_nxt = ~(8'(1) << r_digit_idx);
            w_seg_nxt = w_dec_seg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_sel  <= SEL_OFF;
            r_seg_out  <= SEG_BLANK;
            r_in_ready <= 1'b0;
        end else begin
            r_seg_sel  <= w_sel_nxt;
            r_seg_out  <= w_seg_nxt;
            r_in_ready <= 1'b1;
        end
    end

    // Scan, digit and blink counters; held at zero while the display is off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= '0;
            r_frame_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (w_state_nxt == ST_OFF) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= '0;
            r_frame_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (r_state == ST_OFF) begin
            // First scanning edge shows digit 0 and consumes slot cycle 0.
            r_scan_cnt  <= SCAN_W'(1);
            r_digit_idx <= '0;
            r_frame_cnt <= '0;
            r_blink     <= 1'b0;
        end else begin
            if (r_scan_cnt == SCAN_LAST) begin
                r_scan_cnt  <= '0;
                r_digit_idx <= (r_digit_idx == DIG_LAST) ? '0 : r_digit_idx + DIG_W'(1);
            end else begin
                r_scan_cnt <= r_scan_cnt + SCAN_W'(1);
            end
            if (w_fb) begin
                if (r_frame_cnt == FRAME_LAST) begin
                    r_frame_cnt <= '0;
                    r_blink     <= ~r_blink;
                end else begin
                    r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
                end
            end
        end
    end

    // Result capture: shadow holds the latest accept, display updates at frame edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow  <= '0;
            r_disp    <= '0;
            r_pending <= 1'b0;
        end else begin
            if (w_accept) begin
                r_shadow <= w_in;
            end
            if (w_accept && (!disp_en || w_fb)) begin
                r_disp    <= w_in;
                r_pending <= 1'b0;
            end else if (w_accept) begin
                r_pending <= 1'b1;
            end else if (w_fb && r_pending) begin
                r_disp    <= r_shadow;
                r_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display (SCAN_DIV=4, BLINK_DIV=2).
// Two instances share stimulus: dut_a blanks leading zeros, dut_b does not.
// Expected digit slots are queued by the stimulus; a monitor pops one entry
// every time the digit select changes and also checks each slot lasts 4 cycles.
module tb_seg_scan_display;

    typedef struct {
        logic [7:0] sel;
        logic [7:0] seg_a;
        logic [7:0] seg_b;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] res;
    logic        overflow;
    logic        disp_en;
    logic        in_ready;
    logic        in_ready_b;
    logic [7:0]  seg_sel;
    logic [7:0]  seg_out;
    logic [7:0]  seg_sel_b;
    logic [7:0]  seg_out_b;

    exp_t        exp_q[$];
    int          n_chk;
    int          n_fail;
    int          cur;
    logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg_scan_display #(.DATA_LEN(32), .SCAN_DIV(4), .BLINK_DIV(2), .LZ_SUPPRESS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .res(res), .overflow(overflow), .disp_en(disp_en),
        .seg_sel(seg_sel), .seg_out(seg_out)
    );

    seg_scan_display #(.DATA_LEN(32), .SCAN_DIV(4), .BLINK_DIV(2), .LZ_SUPPRESS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .res(res), .overflow(overflow), .disp_en(disp_en),
        .seg_sel(seg_sel_b), .seg_out(seg_out_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] seg_of(input logic [31:0] v, input logic ov,
                                          input logic ph, input int d, input logic lz);
        logic [31:0] up;
        logic [7:0]  s;
        up = v >> (4 * d);
        if (lz && d > 0 && up == 32'd0) return 8'hFF;
        s = hex_tab[up[3:0]];
        if (ov && ph) s[7] = 1'b0;
        return s;
    endfunction

    task automatic push(input logic [7:0] s, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        e.sel = s; e.seg_a = a; e.seg_b = b;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input logic [31:0] v, input logic ov, input logic ph, input int nd);
        logic [7:0] s;
        for (int d = 0; d < nd; d++) begin
            s = ~(8'(1) << d);
            push(s, seg_of(v, ov, ph, d, 1'b1), seg_of(v, ov, ph, d, 1'b0));
        end
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    // Advance to the negedge just before scan edge k (edge 0 = first edge with disp_en high).
    task automatic goto(input int k);
        repeat (k - cur) @(negedge clk);
        cur = k;
    endtask

    task automatic pulse(input logic [31:0] v, input logic ov);
        check("ready_at_accept", {7'd0, in_ready}, 8'd1);
        in_valid = 1'b1; res = v; overflow = ov;
        @(negedge clk);
        in_valid = 1'b0; res = 32'd0; overflow = 1'b0;
        cur++;
    endtask

    task automatic start_scan();
        disp_en = 1'b1;
        cur = 0;
    endtask

    task automatic end_scan(input int frames);
        goto(32 * frames);
        disp_en = 1'b0;
        push(8'hFF, 8'hFF, 8'hFF);
        repeat (3) @(negedge clk);
    endtask

    task automatic monitor();
        logic [7:0] prev;
        int         len;
        exp_t       e;
        prev = 8'hFF;
        len  = 0;
        forever begin
            @(negedge clk);
            if (seg_sel !== prev) begin
                if (prev != 8'hFF && seg_sel != 8'hFF) begin
                    n_chk++;
                    if (len != 4) begin
                        n_fail++;
                        $display("FAIL slot_len sel=%h: got %0d cycles, expected 4", prev, len);
                    end
                end
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_slot: got sel=%h seg=%h, nothing expected",
                             seg_sel, seg_out);
                end else begin
                    e = exp_q.pop_front();
                    if (seg_sel !== e.sel || seg_sel_b !== e.sel ||
                        seg_out !== e.seg_a || seg_out_b !== e.seg_b) begin
                        n_fail++;
                        $display("FAIL slot: got sel=%h/%h seg=%h/%h, expected sel=%h seg=%h/%h",
                                 seg_sel, seg_sel_b, seg_out, seg_out_b, e.sel, e.seg_a, e.seg_b);
                    end
                end
                prev = seg_sel;
                len  = 1;
            end else begin
                len++;
            end
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cur = 0;
        rst_n = 1'b0; in_valid = 1'b0; res = 32'd0; overflow = 1'b0; disp_en = 1'b0;
        fork
            monitor();
        join_none

        // Reset values and in_ready release.
        repeat (3) @(negedge clk);
        check("rst_sel", seg_sel, 8'hFF);
        check("rst_seg", seg_out, 8'hFF);
        check("rst_ready", {7'd0, in_ready}, 8'd0);
        rst_n = 1'b1;
        #1 check("ready_before_edge", {7'd0, in_ready}, 8'd0);
        @(negedge clk);
        check("ready_after_edge", {7'd0, in_ready}, 8'd1);
        check("ready_after_edge_b", {7'd0, in_ready_b}, 8'd1);

        // 0000_12AF loaded while off, one frame.
        pulse(32'h0000_12AF, 1'b0);
        push(8'hFE, 8'h8E, 8'h8E); push(8'hFD, 8'h88, 8'h88);
        push(8'hFB, 8'hA4, 8'hA4); push(8'hF7, 8'hF9, 8'hF9);
        push(8'hEF, 8'hFF, 8'hC0); push(8'hDF, 8'hFF, 8'hC0);
        push(8'hBF, 8'hFF, 8'hC0); push(8'h7F, 8'hFF, 8'hC0);
        start_scan();
        end_scan(1);

        // All ones with overflow: dp blinks every 2 frames.
        pulse(32'hFFFF_FFFF, 1'b1);
        push_frame(32'hFFFF_FFFF, 1'b1, 1'b0, 8);
        push_frame(32'hFFFF_FFFF, 1'b1, 1'b0, 8);
        push_frame(32'hFFFF_FFFF, 1'b1, 1'b1, 8);
        push_frame(32'hFFFF_FFFF, 1'b1, 1'b1, 8);
        start_scan();
        end_scan(4);

        // Zero value: only digit 0 lit when blanking.
        pulse(32'd0, 1'b0);
        push_frame(32'd0, 1'b0, 1'b0, 8);
        start_scan();
        end_scan(1);

        // Tear-free update, latest-wins, and accept on the frame boundary.
        push_frame(32'd0, 1'b0, 1'b0, 8);
        push_frame(32'h1111_1111, 1'b0, 1'b0, 8);
        push_frame(32'h3333_3333, 1'b0, 1'b0, 8);
        push_frame(32'h4444_4444, 1'b0, 1'b0, 8);
        start_scan();
        goto(13); pulse(32'h1111_1111, 1'b0);
        goto(40); pulse(32'h2222_2222, 1'b0);
        goto(50); pulse(32'h3333_3333, 1'b0);
        goto(95); pulse(32'h4444_4444, 1'b0);
        end_scan(4);

        // Enable dropped while digit 5 shows, then a fresh frame.
        push_frame(32'h4444_4444, 1'b0, 1'b0, 6);
        push(8'hFF, 8'hFF, 8'hFF);
        start_scan();
        goto(22);
        disp_en = 1'b0;
        repeat (3) @(negedge clk);
        push_frame(32'h4444_4444, 1'b0, 1'b0, 8);
        start_scan();
        end_scan(1);

        // Reset mid-frame with a pending value: the pending value is lost.
        push_frame(32'h4444_4444, 1'b0, 1'b0, 3);
        push(8'hFF, 8'hFF, 8'hFF);
        start_scan();
        goto(5); pulse(32'h5555_5555, 1'b0);
        goto(11);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_sel", seg_sel, 8'hFF);
        check("midrst_seg", seg_out, 8'hFF);
        check("midrst_ready", {7'd0, in_ready}, 8'd0);
        disp_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready_release", {7'd0, in_ready}, 8'd1);
        push_frame(32'd0, 1'b0, 1'b0, 8);
        start_scan();
        end_scan(1);

        repeat (5) @(negedge clk);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drained: got %0d slots still expected, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
